// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared definitions for the sprite fetch arbiter.
// Contents: the field widths, the transparent colour default, the FSM state
// encoding and the {frame, y, x} address pack helper.
package sprite_pkg;

  localparam int SPR_W  = 3;   // sprite bank select
  localparam int FRM_W  = 4;   // animation frame index
  localparam int XY_W   = 6;   // pixel coordinate / sprite size
  localparam int COL_W  = 9;   // RGB333 colour
  localparam int ADDR_W = 16;  // sprite memory pixel address

  localparam logic [COL_W-1:0] TRANSPARENT_DEF = 9'h1C7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  // Fixed 64x64 stride per frame, so the address is a plain concatenation.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [FRM_W-1:0] f,
                                                  input logic [XY_W-1:0]  y,
                                                  input logic [XY_W-1:0]  x);
    return {f, y, x};
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the sprite memory.
//   requester side : Req, ReqSprite, ReqFrame, ReqX, ReqY -> Ack, RespData, Busy
//   memory side    : MemSel, Address -> MemData, Width, Height, AnimSteps
// The slave modport is the arbiter's view; the master modport is everything
// around it (requesters plus memory).
interface sprite_fetch_arbiter_if
  import sprite_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]        Req;
  logic [SPR_W*NREQ-1:0]  ReqSprite;
  logic [FRM_W*NREQ-1:0]  ReqFrame;
  logic [XY_W*NREQ-1:0]   ReqX;
  logic [XY_W*NREQ-1:0]   ReqY;
  logic [NREQ-1:0]        Ack;
  logic [COL_W-1:0]       RespData;
  logic                   Busy;
  logic [SPR_W-1:0]       MemSel;
  logic [ADDR_W-1:0]      Address;
  logic [COL_W-1:0]       MemData;
  logic [XY_W-1:0]        Width;
  logic [XY_W-1:0]        Height;
  logic [2:0]             AnimSteps;

  modport slave (
    input  Req, ReqSprite, ReqFrame, ReqX, ReqY, MemData, Width, Height, AnimSteps,
    output Ack, RespData, Busy, MemSel, Address
  );

  modport master (
    output Req, ReqSprite, ReqFrame, ReqX, ReqY, MemData, Width, Height, AnimSteps,
    input  Ack, RespData, Busy, MemSel, Address
  );

endinterface

// File: rtl/sprite_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i : pending requests
//   ptr_i : last winner; the search starts at ptr_i+1 and wraps
//   gnt_o : one-hot grant (all zero when nothing is pending)
//   idx_o : binary index of the granted requester
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    logic found;
    int   c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    // k = NREQ lands back on ptr_i itself, so the last winner is lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares one sprite memory among NREQ pixel-fetch requesters.
//   Clock, Resetn : system clock, synchronous active-low reset
//   bus (slave)   : requester handshake (Req/fields in, Ack/RespData/Busy out)
//                   and sprite memory port (MemSel/Address out, MemData and
//                   sprite info in, sprite info combinational from MemSel)
// Grant in IDLE, memory read in ADDR, bounds check + response in DATA; the
// Ack pulse appears in the following (IDLE) cycle, overlapping the next grant.
module sprite_fetch_arbiter
  import sprite_pkg::*;
#(
  parameter int               NREQ        = 4,
  parameter logic [COL_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  sprite_fetch_arbiter_if.slave  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   win_q, win_d;      // one-hot winner, becomes Ack
  logic [SPR_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  resp_q, resp_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i (bus.Req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // The latched request fields live only in the address register.
  logic [XY_W-1:0]  lx, ly;
  logic [FRM_W-1:0] lf;
  logic             oob;
  assign lx  = addr_q[XY_W-1:0];
  assign ly  = addr_q[2*XY_W-1:XY_W];
  assign lf  = addr_q[ADDR_W-1:2*XY_W];
  assign oob = (lx >= bus.Width) || (ly >= bus.Height) || lf[3] ||
               (lf[2:0] > bus.AnimSteps);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.Req) begin
          win_d   = gnt;
          ptr_d   = gnt_idx;
          sel_d   = bus.ReqSprite[gnt_idx*SPR_W +: SPR_W];
          addr_d  = pack_addr(bus.ReqFrame[gnt_idx*FRM_W +: FRM_W],
                              bus.ReqY[gnt_idx*XY_W +: XY_W],
                              bus.ReqX[gnt_idx*XY_W +: XY_W]);
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        resp_d  = oob ? TRANSPARENT : bus.MemData;
        ack_d   = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      win_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.Ack      = ack_q;
  assign bus.RespData = resp_q;
  assign bus.MemSel   = sel_q;
  assign bus.Address  = addr_q;
  assign bus.Busy     = (state_q != ST_IDLE);

endmodule
